mem_arbiter: RTL and testbench

- Sits directly downstream of the dcache and icache, between both caches and the single-ported RAM.
- Arbitrates instruction fetches and data block fills, write-backs and flushes onto one RAM port, one word per grant.
- Returns per-client wait and load data, matching the existing cache-side handshake: a cache holds its request until wait drops.
- Adds a RAM-latency watchdog with a sticky error flag.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/arb_watchdog.sv | 16 +
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM status, arbiter state and word types for the cache-to-RAM path.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE = 2'd0, D_ACC = 2'd1, I_ACC = 2'd2} arb_state_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts granted non-ACCESS cycles and flags when a RAM access has waited too long.
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYC);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (rst || clear) ? '0 : inc ? cnt + 1'b1 : cnt;
    assign expire = cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between dcache and icache, one word per grant, with a latency watchdog.
// Build option ARB_STARVE_GUARD_EN lets the icache in after STARVE_MAX back-to-back dcache words.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int STARVE_MAX  = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    output logic  iwait,
    output word_t iload,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dwait,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    input  logic [1:0] ramstate,
    output logic  arb_err
);
    arb_state_t state;
    ramstate_t rs;
    logic d_req, access, ram_err, granted, expire, stay, fault, d_done, i_done, grant_i;
    assign rs      = ramstate_t'(ramstate);
    assign d_req   = dREN | dWEN;
    assign access  = rs == ACCESS;
    assign ram_err = rs == ERROR;
    // A grant whose client has dropped its request is no longer live
    assign granted = (state == D_ACC && d_req) || (state == I_ACC && iREN);
    assign d_done  = state == D_ACC && d_req && access;
    assign i_done  = state == I_ACC && iREN && access;
    assign stay    = granted && !access && !ram_err && !expire;
    assign fault   = (granted && (ram_err || (expire && !access))) || (state == D_ACC && dREN && dWEN);
    arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk   (CLK),
        .rst   (RST),
        .clear (state == IDLE),
        .inc   (granted && !access),
        .expire(expire)
    );
`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    logic [SW-1:0] starve;
    always_ff @(posedge CLK)
        if (RST || !iREN || i_done) starve <= '0;
        else if (d_done && starve != SMAX) starve <= starve + 1'b1;
    assign grant_i = iREN && starve == SMAX;
`else
    assign grant_i = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            arb_err <= 1'b0;
        end else begin
            if (state == IDLE)
                state <= grant_i ? I_ACC : d_req ? D_ACC : iREN ? I_ACC : IDLE;
            else if (!stay)
                state <= IDLE;
            if (fault) arb_err <= 1'b1;
        end
    end
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state == D_ACC) begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
        end else if (state == I_ACC) begin
            ramREN  = iREN;
            ramaddr = iaddr;
        end
    end
    assign dwait = !d_done;
    assign iwait = !i_done;
    assign dload = d_done ? ramload : '0;
    assign iload = i_done ? ramload : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int TO = 64, SM = 4;
    logic CLK = 0, RST = 1, iREN = 0, dREN = 0, dWEN = 0;
    logic ramREN, ramWEN, iwait, dwait, arb_err;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0] ramstate = 0;
    int total = 0, passed = 0;
    int own = 0, age = 0, starve = 0;
    bit err = 0;
    int seq[$];
    logic [31:0] dq[$];

    mem_arbiter #(.TIMEOUT_CYC(TO), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: got %h want %h", tag, got, want);
    endtask

    // own: 0 = nobody holds the RAM, 1 = dcache, 2 = icache; age = granted cycles without ACCESS
    task automatic step();
        bit dlive, live, acc, dd, id;
        logic [31:0] ea, es;
        logic er, ew;
        dlive = dREN | dWEN;
        acc = ramstate == 2'd2;
        ea = 0; es = 0; er = 0; ew = 0;
        if (own == 1) begin ea = daddr; es = dstore; ew = dWEN; er = dREN & !dWEN; end
        if (own == 2) begin ea = iaddr; er = iREN; end
        dd = own == 1 && dlive && acc;
        id = own == 2 && iREN && acc;
        #3;
        chk("ramREN", ramREN, er);
        chk("ramWEN", ramWEN, ew);
        chk("ramaddr", ramaddr, ea);
        chk("ramstore", ramstore, es);
        chk("dwait", dwait, !dd);
        chk("dload", dload, dd ? ramload : 0);
        chk("iwait", iwait, !id);
        chk("iload", iload, id ? ramload : 0);
        chk("arb_err", arb_err, err);
        if (dwait === 1'b0) begin seq.push_back(1); dq.push_back(daddr); end
        if (iwait === 1'b0) seq.push_back(2);
        @(posedge CLK);
        #1;
        if (RST) begin
            own = 0; age = 0; err = 0; starve = 0;
        end else begin
            if (own == 1 && dREN && dWEN) err = 1;
            if (own == 0) begin
                own = (iREN && starve == SM) ? 2 : dlive ? 1 : iREN ? 2 : 0;
                age = 0;
            end else begin
                live = own == 1 ? dlive : iREN;
                if (live && (ramstate == 2'd3 || (age == TO - 1 && !acc))) err = 1;
                if (!live || acc || ramstate == 2'd3 || age == TO - 1) own = 0;
                else age++;
            end
`ifdef ARB_STARVE_GUARD_EN
            if (!iREN || id) starve = 0;
            else if (dd && starve < SM) starve++;
`endif
        end
    endtask

    task automatic do_reset();
        RST = 1;
        step();
        RST = 0;
    endtask

    initial begin
        int words, ic;
        @(posedge CLK);
        #1;
        RST = 0;
        step();
        step();

        // Single icache fetch completing on the first granted cycle
        iREN = 1; iaddr = 32'h40;
        step();
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        #2;
        chk("t1_ramREN", ramREN, 1);
        chk("t1_iload", iload, 32'hDEADBEEF);
        step();
        iREN = 0; ramstate = 0;
        step();

        // Simultaneous write and fetch: data wins, fetch follows
        dWEN = 1; iREN = 1; daddr = 32'h100; dstore = 32'h12345678; iaddr = 32'h80;
        step();
        ramstate = 2'd2;
        #2;
        chk("t2_ramWEN", ramWEN, 1);
        chk("t2_ramaddr", ramaddr, 32'h100);
        step();
        dWEN = 0; ramstate = 0;
        step();
        #2;
        chk("t2_ifollow", ramaddr, 32'h80);
        ramstate = 2'd2;
        step();
        iREN = 0; ramstate = 0;
        step();

        // Two-word block fill with icache pending; data words complete in order first
        dq.delete(); seq.delete();
        dREN = 1; iREN = 1; daddr = 32'h200; ramstate = 2'd2; words = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (seq.size() > 0 && seq[$] == 1) begin
                seq.delete();
                words++;
                daddr = 32'h204;
                if (words == 2) dREN = 0;
            end
        end
        chk("fill_words", dq.size(), 2);
        if (dq.size() == 2) begin
            chk("fill_w0", dq[0], 32'h200);
            chk("fill_w1", dq[1], 32'h204);
        end
        iREN = 0; ramstate = 0;
        step();

        // Watchdog: RAM stuck BUSY
        dWEN = 1; daddr = 32'h300; ramstate = 2'd1;
        for (int i = 0; i < TO; i++) step();
        chk("wd_before", arb_err, 0);
        step();
        chk("wd_err", arb_err, 1);
        chk("wd_dwait", dwait, 1);
        dWEN = 0; ramstate = 0;
        step(); step(); step();
        chk("wd_sticky", arb_err, 1);

        // Reset in the middle of a write
        do_reset();
        dWEN = 1; daddr = 32'h400; ramstate = 2'd1;
        step();
        #2;
        chk("rst_pre_wen", ramWEN, 1);
        RST = 1;
        step();
        RST = 0;
        #2;
        chk("rst_wen", ramWEN, 0);
        chk("rst_err", arb_err, 0);
        step();
        dWEN = 0; ramstate = 0;
        step();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            if (i % 200 == 0) do_reset();
            iREN = $urandom_range(0, 1);
            iaddr = $urandom;
            r = $urandom_range(0, 31);
            dREN = r < 10 || r == 31;
            dWEN = (r >= 10 && r < 18) || r == 31;
            daddr = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 7);
            ramstate = r < 2 ? 2'd0 : r < 4 ? 2'd1 : r < 7 ? 2'd2 : 2'd3;
            step();
        end

        // Continuous data and icache demand
        do_reset();
        seq.delete();
        dREN = 1; iREN = 1; daddr = 32'h500; iaddr = 32'h600; ramstate = 2'd2;
        for (int i = 0; i < 24; i++) step();
        ic = 0;
        foreach (seq[k]) if (seq[k] == 2) ic++;
`ifdef ARB_STARVE_GUARD_EN
        chk("guard_len", seq.size(), 12);
        for (int k = 0; k < 10 && k < seq.size(); k++)
            chk("guard_seq", seq[k], (k % 5 == 4) ? 2 : 1);
`else
        chk("strict_prio", ic, 0);
`endif
        dREN = 0; iREN = 0; ramstate = 0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
